data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_if.sv | 21 ++
 rtl/data_mem.sv | 121 ++++++++++++
 tb/tb_data_mem.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - core-side load/store bus for the data memory
interface data_mem_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic        clk_stall;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, led, clk_stall
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, led, clk_stall
    );
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory with byte/halfword access and an LED register
module data_mem #(
    parameter int          MEM_WORDS = 2048,
    parameter logic [31:0] LED_ADDR  = 32'h0000_2000
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, READ_BUF, READ, WRITE} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        is_write_q;
    logic [31:0] buf_q;
    logic [31:0] rdata_q;
    logic [7:0]  led_q;
    logic        stall_q;

    logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

    logic [IDX_W-1:0] idx;
    logic             in_mem;
    logic             is_led;
    logic             is_byte;
    logic             is_half;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_d;
    logic [31:0]      merge_d;

    assign idx      = addr_q[IDX_W+1:2];
    assign is_led   = (addr_q == LED_ADDR);
    assign in_mem   = (addr_q < MEM_BYTES) && !is_led;
    assign is_byte  = (mask_q[2:0] == 3'b001);
    assign is_half  = (mask_q[2:0] == 3'b011);
    assign byte_sel = buf_q[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = buf_q[{addr_q[1], 4'b0000} +: 16];

    // Any size encoding other than byte/halfword falls through to a full word.
    always_comb begin
        load_d = buf_q;
        if (is_led)
            load_d = {24'b0, led_q};
        else if (is_byte)
            load_d = {{24{mask_q[3] & byte_sel[7]}}, byte_sel};
        else if (is_half)
            load_d = {{16{mask_q[3] & half_sel[15]}}, half_sel};
    end

    always_comb begin
        merge_d = buf_q;
        if (is_byte)
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (is_half)
            merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merge_d = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            is_write_q <= 1'b0;
            buf_q      <= '0;
            rdata_q    <= '0;
            led_q      <= '0;
            stall_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.memwrite || bus.memread) begin
                        addr_q     <= bus.addr;
                        wdata_q    <= bus.write_data;
                        mask_q     <= bus.sign_mask;
                        is_write_q <= bus.memwrite;
                        state_q    <= READ_BUF;
                        stall_q    <= 1'b1;
                    end
                end
                READ_BUF: begin
                    buf_q   <= in_mem ? mem_q[idx] : '0;
                    state_q <= is_write_q ? WRITE : READ;
                end
                READ: begin
                    rdata_q <= load_d;
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                WRITE: begin
                    if (is_led)
                        led_q <= wdata_q[7:0];
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; gating on rst_n keeps an aborted store from landing.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == WRITE && in_mem)
            mem_q[idx] <= merge_d;
    end

    assign bus.read_data = rdata_q;
    assign bus.led       = led_q;
    assign bus.clk_stall = stall_q;
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - randomized check of data_mem against a byte-array model
module tb_data_mem;
    localparam logic [31:0] LED_A = 32'h0000_2000;
    localparam int          NBYTES = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_if bus ();

    data_mem #(.MEM_WORDS(2048), .LED_ADDR(LED_A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mbytes [NBYTES];
    logic [7:0]  exp_led   = '0;
    logic [31:0] exp_rd    = '0;
    logic        exp_stall = 1'b0;
    bit          cmp_en    = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic int size_of(input logic [3:0] m);
        if (m[2:0] == 3'b001) return 1;
        if (m[2:0] == 3'b011) return 2;
        return 4;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int sz = size_of(m);
        int base;
        if (a == LED_A) begin
            exp_led = d[7:0];
            return;
        end
        if (a >= NBYTES) return;
        base = int'(a) & ~(sz - 1);
        for (int i = 0; i < sz; i++) mbytes[base + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] m);
        int sz = size_of(m);
        int base;
        logic [31:0] v = '0;
        if (a == LED_A) return {24'b0, exp_led};
        if (a >= NBYTES) return '0;
        base = int'(a) & ~(sz - 1);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mbytes[base + i];
        if (m[3] && sz == 1 && v[7])  v[31:8]  = '1;
        if (m[3] && sz == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("clk_stall", {31'b0, bus.clk_stall}, {31'b0, exp_stall});
            check("read_data", bus.read_data, exp_rd);
            check("led", {24'b0, bus.led}, {24'b0, exp_led});
        end
    end

    // Called at a falling edge; returns at the falling edge after the access completes.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input bit garbage);
        bus.addr = a; bus.write_data = d; bus.sign_mask = m;
        bus.memwrite = wr; bus.memread = !wr;
        @(posedge clk); #1;
        exp_stall = 1'b1;
        if (garbage) begin
            bus.memwrite = 1'($urandom); bus.memread = 1'($urandom);
            bus.addr = $urandom; bus.write_data = $urandom; bus.sign_mask = 4'($urandom);
        end else begin
            bus.memwrite = 1'b0; bus.memread = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.memwrite = 1'b0; bus.memread = 1'b0;
        exp_stall = 1'b0;
        if (wr) model_store(a, d, m);
        else    exp_rd = model_load(a, m);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return LED_A;
            1:       return 32'h2000 + 32'($urandom_range(1, 16'hFFFF));
            2:       return 32'($urandom_range(0, NBYTES - 1));
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [3:0] rand_mask();
        case ($urandom_range(0, 7))
            0: return 4'b0001;
            1: return 4'b1001;
            2: return 4'b0011;
            3: return 4'b1011;
            4: return 4'b0111;
            5: return 4'b1111;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NBYTES; i++) mbytes[i] = '0;
        bus.addr = '0; bus.write_data = '0; bus.sign_mask = '0;
        bus.memwrite = 1'b0; bus.memread = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_stall", {31'b0, bus.clk_stall}, 32'd0);
        check("reset_rd", bus.read_data, 32'd0);
        check("reset_led", {24'b0, bus.led}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        access(1'b0, 32'h0000_0600, 32'h0, 4'b0111, 1'b0);
        check("powerup_zero", bus.read_data, 32'h0);

        access(1'b1, 32'h0000_0400, 32'h0000_0AAA, 4'b0001, 1'b0);
        access(1'b0, 32'h0000_0400, 32'h0, 4'b1001, 1'b0);
        check("byte_signed", bus.read_data, 32'hFFFF_FFAA);
        access(1'b0, 32'h0000_0400, 32'h0, 4'b0001, 1'b0);
        check("byte_unsigned", bus.read_data, 32'h0000_00AA);

        access(1'b1, 32'h0000_0100, 32'h0002_AAAA, 4'b0011, 1'b0);
        access(1'b0, 32'h0000_0100, 32'h0, 4'b1011, 1'b0);
        check("half_signed", bus.read_data, 32'hFFFF_AAAA);
        access(1'b0, 32'h0000_0100, 32'h0, 4'b0011, 1'b0);
        check("half_unsigned", bus.read_data, 32'h0000_AAAA);

        access(1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 4'b0111, 1'b0);
        access(1'b0, 32'h0000_0040, 32'h0, 4'b0111, 1'b0);
        check("word", bus.read_data, 32'hAAAA_AAAA);

        access(1'b1, 32'h0000_0080, 32'h1122_3344, 4'b0111, 1'b0);
        access(1'b1, 32'h0000_0082, 32'h0000_0055, 4'b0001, 1'b0);
        access(1'b0, 32'h0000_0080, 32'h0, 4'b0111, 1'b0);
        check("merge_word", bus.read_data, 32'h1155_3344);
        access(1'b0, 32'h0000_0083, 32'h0, 4'b0011, 1'b0);
        check("merge_half_a0_ignored", bus.read_data, 32'h0000_1155);

        access(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b0111, 1'b0);
        access(1'b1, LED_A, 32'h0000_015A, 4'b0111, 1'b0);
        check("led_store", {24'b0, bus.led}, 32'h0000_005A);
        access(1'b0, 32'h0000_0000, 32'h0, 4'b0111, 1'b0);
        check("led_no_mem", bus.read_data, 32'hCAFE_F00D);
        access(1'b0, LED_A, 32'h0, 4'b0111, 1'b0);
        check("led_load", bus.read_data, 32'h0000_005A);

        access(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b0111, 1'b0);
        access(1'b0, 32'h0000_3000, 32'h0, 4'b0111, 1'b0);
        check("oor_load", bus.read_data, 32'h0);

        for (int k = 0; k < 400; k++) begin
            access(1'($urandom), rand_addr(), $urandom, rand_mask(), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        access(1'b1, 32'h0000_0300, 32'h1234_5678, 4'b0111, 1'b0);
        access(1'b1, LED_A, 32'h0000_00C3, 4'b0001, 1'b0);
        access(1'b0, 32'h0000_0300, 32'h0, 4'b0111, 1'b0);
        bus.addr = 32'h0000_0300; bus.write_data = 32'hDEAD_BEEF; bus.sign_mask = 4'b0111;
        bus.memwrite = 1'b1; bus.memread = 1'b0;
        @(posedge clk); #1;
        bus.memwrite = 1'b0;
        cmp_en = 1'b0;
        check("pre_abort_stall", {31'b0, bus.clk_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_stall", {31'b0, bus.clk_stall}, 32'd0);
        check("abort_led", {24'b0, bus.led}, 32'd0);
        check("abort_rd", bus.read_data, 32'd0);
        exp_led = '0; exp_rd = '0; exp_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        access(1'b0, 32'h0000_0300, 32'h0, 4'b0111, 1'b0);
        check("abort_mem_kept", bus.read_data, 32'h1234_5678);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
